// File: rtl/dmem_if.sv
// Request/response bundle between the core's load/store port and dmem_responder.
// The core drives through the master modport; the responder uses the slave modport.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte/half/word loads and stores, fixed LATENCY.
// Define DMEM_RESP_ERR_CHECK_EN for size, alignment and range fault checking.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             access;
    logic             acc_we, acc_uns, acc_err;
    logic [31:0]      acc_addr, acc_wdata;
    logic [1:0]       acc_size, eff_size, off;
    logic [IDX_W-1:0] widx;
    logic [3:0]       be;
    logic [31:0]      rd_shift, load_data, wr_shift;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
        case (sz)
            2'b00:   return uns ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   return uns ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    // With LATENCY=1 the access happens on the accept edge, so decode the live request then.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_size  = size_q;
        acc_uns   = uns_q;
        if (state_q == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_size  = bus.req_size;
            acc_uns   = bus.req_unsigned;
        end
`ifdef DMEM_RESP_ERR_CHECK_EN
        eff_size = acc_size;
        off      = acc_addr[1:0];
        widx     = IDX_W'(acc_addr[31:2]);
        acc_err  = (acc_size == 2'b11)
                || (acc_size == 2'b01 && acc_addr[0])
                || (acc_size == 2'b10 && acc_addr[1:0] != 2'b00)
                || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
        eff_size = (acc_size == 2'b11) ? 2'b10 : acc_size;
        case (eff_size)
            2'b00:   off = acc_addr[1:0];
            2'b01:   off = {acc_addr[1], 1'b0};
            default: off = 2'b00;
        endcase
        widx     = IDX_W'({2'b00, acc_addr[31:2]} % 32'(DEPTH_WORDS));
        acc_err  = 1'b0;
`endif
        case (eff_size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        rd_shift  = mem[widx] >> {off, 3'b000};
        load_data = extend(rd_shift, eff_size, acc_uns);
        wr_shift  = acc_wdata << {off, 3'b000};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        access      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    size_d      = bus.req_size;
                    uns_d       = bus.req_unsigned;
                    cnt_d       = 4'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (access) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_we || acc_err) ? 32'h0 : load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
    end

    // Storage survives reset; a store landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst && access && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wr_shift[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance against a byte-array model, LATENCY=4 instance
// for mid-operation reset. Expected responses go through a scoreboard queue.
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_valid, req_we, req_uns, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [7:0]  mb [int unsigned];

    dmem_if a_if();
    dmem_if b_if();

    assign a_if.req_valid    = req_valid && !sel;
    assign b_if.req_valid    = req_valid && sel;
    assign a_if.req_we       = req_we;
    assign b_if.req_we       = req_we;
    assign a_if.req_addr     = req_addr;
    assign b_if.req_addr     = req_addr;
    assign a_if.req_wdata    = req_wdata;
    assign b_if.req_wdata    = req_wdata;
    assign a_if.req_size     = req_size;
    assign b_if.req_size     = req_size;
    assign a_if.req_unsigned = req_uns;
    assign b_if.req_unsigned = req_uns;
    assign a_if.rsp_ready    = rsp_ready;
    assign b_if.rsp_ready    = rsp_ready;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

    wire        cur_req_ready = sel ? b_if.req_ready : a_if.req_ready;
    wire        cur_rsp_valid = sel ? b_if.rsp_valid : a_if.rsp_valid;
    wire [31:0] cur_rsp_rdata = sel ? b_if.rsp_rdata : a_if.rsp_rdata;
    wire        cur_rsp_err   = sel ? b_if.rsp_err   : a_if.rsp_err;

    // Byte-addressed reference for the LATENCY=2 instance.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] sz, input logic uns,
                         output logic [31:0] rd, output logic err);
        logic [1:0]  s;
        logic [31:0] a;
        int          nb;
        s  = sz;
        a  = addr;
        rd = '0;
`ifdef DMEM_RESP_ERR_CHECK_EN
        err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)
           || (addr[31:2] >= 30'(DEPTH));
`else
        err = 1'b0;
        if (s == 2'b11) s = 2'b10;
        a[1:0]  = (s == 2'b00) ? addr[1:0] : (s == 2'b01) ? {addr[1], 1'b0} : 2'b00;
        a[31:2] = 30'(addr[31:2] % 30'(DEPTH));
`endif
        nb = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        if (!err) begin
            for (int i = 0; i < nb; i++) begin
                if (we) mb[a + 32'(i)] = wdata[8*i +: 8];
                else    rd[8*i +: 8] = mb[a + 32'(i)];
            end
            if (!we && !uns && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
        end
    endtask

    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] sz, input logic uns,
                          input logic [31:0] exp_rd, input logic exp_err, input int hold,
                          input bit early, input bit now,
                          output logic [31:0] got_rd, output logic got_err);
        int   t;
        int   lat;
        exp_t e;
        lat = sel ? 4 : 2;
        t = 0;
        while (!cur_req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (t >= 50 || (now && t != 0)) begin
            errors++;
            $display("FAIL %s accept: waited %0d cycles for req_ready, required %0s", name, t,
                     now ? "0" : "fewer than 50");
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = sz;
        req_uns   = uns;
        rsp_ready = early;
        sb.push_back('{exp_rd, exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (!cur_rsp_valid && t < 50) begin
            checks++;
            if (cur_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_ready: req_ready=%b required 0", name, cur_req_ready);
            end
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (t != lat - 1) begin
            errors++;
            $display("FAIL %s latency: rsp_valid after %0d extra cycles, required %0d", name, t, lat - 1);
        end
        e = sb.pop_front();
        got_rd  = cur_rsp_rdata;
        got_err = cur_rsp_err;
        checks++;
        if (cur_rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h required %h", name, cur_rsp_rdata, e.rdata);
        end
        checks++;
        if (cur_rsp_err !== e.err) begin
            errors++;
            $display("FAIL %s err: got %b required %b", name, cur_rsp_err, e.err);
        end
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 32'h10;
                req_wdata = 32'h0BAD_F00D;
                req_size  = 2'b10;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            checks++;
            if (cur_rsp_valid !== 1'b1 || cur_rsp_rdata !== got_rd || cur_rsp_err !== got_err
                || cur_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                         name, i, cur_rsp_valid, cur_rsp_rdata, cur_rsp_err, cur_req_ready,
                         got_rd, got_err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (cur_rsp_valid !== 1'b0 || cur_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: rsp_valid=%b req_ready=%b required 0 1", name,
                     cur_rsp_valid, cur_req_ready);
        end
    endtask

    task automatic req_a(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] sz, input logic uns,
                         input int hold, input bit early, input bit now,
                         output logic [31:0] got_rd, output logic got_err);
        logic [31:0] m_rd;
        logic        m_err;
        sel = 1'b0;
        model(we, addr, wdata, sz, uns, m_rd, m_err);
        do_req(name, we, addr, wdata, sz, uns, m_rd, m_err, hold, early, now, got_rd, got_err);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_if.req_ready !== 1'b0 || a_if.rsp_valid !== 1'b0 || a_if.rsp_rdata !== 32'h0
            || a_if.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: ready=%b valid=%b rdata=%h err=%b required 0 0 0 0",
                     a_if.req_ready, a_if.rsp_valid, a_if.rsp_rdata, a_if.rsp_err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_if.req_ready !== 1'b1 || a_if.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b required 1 0", a_if.req_ready, a_if.rsp_valid);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        req_a("st_word", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 1'b0, 1'b0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL st_word_rsp: rdata=%h err=%b required 00000000 0", rd, er);
        end
        req_a("ld_word", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, 1'b0, rd, er);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ld_word_val: got %h required deadbeef", rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        er;
        req_a("ld_sb13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, 1'b0, 1'b0, rd, er);
        checks++;
        if (rd !== 32'hFFFF_FFDE) begin
            errors++;
            $display("FAIL ld_sb13_val: got %h required ffffffde", rd);
        end
        req_a("ld_ub13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, 1'b0, 1'b0, rd, er);
        checks++;
        if (rd !== 32'h0000_00DE) begin
            errors++;
            $display("FAIL ld_ub13_val: got %h required 000000de", rd);
        end
        req_a("ld_sh12", 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 0, 1'b0, 1'b0, rd, er);
        checks++;
        if (rd !== 32'hFFFF_DEAD) begin
            errors++;
            $display("FAIL ld_sh12_val: got %h required ffffdead", rd);
        end
        req_a("ld_uh10", 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 0, 1'b0, 1'b0, rd, er);
        req_a("ld_sb10", 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 0, 1'b0, 1'b0, rd, er);
        req_a("ld_ub11", 1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 0, 1'b0, 1'b0, rd, er);
    endtask

    task automatic test_partial_store();
        logic [31:0] rd;
        logic        er;
        req_a("st_b11", 1'b1, 32'h11, 32'h0000_0055, 2'b00, 1'b0, 0, 1'b0, 1'b0, rd, er);
        req_a("ld_w10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, 1'b0, rd, er);
        checks++;
        if (rd !== 32'hDEAD_55EF) begin
            errors++;
            $display("FAIL partial_val: got %h required dead55ef", rd);
        end
        req_a("st_h16", 1'b1, 32'h16, 32'hFFFF_8001, 2'b01, 1'b0, 0, 1'b0, 1'b0, rd, er);
        req_a("ld_w14", 1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 0, 1'b0, 1'b0, rd, er);
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        req_a("st_w00", 1'b1, 32'h0, 32'hCAFE_F00D, 2'b10, 1'b0, 0, 1'b0, 1'b0, rd, er);
        req_a("ld_w02", 1'b0, 32'h2, 32'h0, 2'b10, 1'b0, 0, 1'b0, 1'b0, rd, er);
        checks++;
`ifdef DMEM_RESP_ERR_CHECK_EN
        if (rd !== 32'h0 || er !== 1'b1) begin
`else
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
`endif
            errors++;
            $display("FAIL misalign_val: rdata=%h err=%b", rd, er);
        end
        req_a("st_oob", 1'b1, 32'(4 * DEPTH), 32'h1111_1111, 2'b10, 1'b0, 0, 1'b0, 1'b0, rd, er);
        req_a("ld_w00", 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 0, 1'b0, 1'b0, rd, er);
        checks++;
`ifdef DMEM_RESP_ERR_CHECK_EN
        if (rd !== 32'hCAFE_F00D) begin
`else
        if (rd !== 32'h1111_1111) begin
`endif
            errors++;
            $display("FAIL oob_mem: got %h", rd);
        end
        req_a("ld_sz3", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, 1'b0, 1'b0, rd, er);
        req_a("ld_h11", 1'b0, 32'h11, 32'h0, 2'b01, 1'b1, 0, 1'b0, 1'b0, rd, er);
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        req_a("bp_ld", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, 1'b0, 1'b0, rd, er);
        req_a("b2b_ld", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, 1'b0, 1'b1, rd, er);
        req_a("early_rdy", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b1, 1'b1, rd, er);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        sel = 1'b1;
        do_req("b_st_init", 1'b1, 32'h20, 32'hA5A5_A5A5, 2'b10, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, rd, er);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        req_size  = 2'b10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (b_if.req_ready !== 1'b0 || b_if.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_accept: ready=%b valid=%b required 0 0", b_if.req_ready, b_if.rsp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (b_if.rsp_valid !== 1'b0 || b_if.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b_post_reset%0d: valid=%b ready=%b required 0 1", i,
                         b_if.rsp_valid, b_if.req_ready);
            end
        end
        do_req("b_ld_20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hA5A5_A5A5, 1'b0, 0, 1'b0, 1'b0, rd, er);
        req_a("a_keep", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, 1'b0, rd, er);
    endtask

    initial begin
        rst       = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_uns   = 1'b0;
        rsp_ready = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = 2'b00;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
